// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and operand-signedness decode for the iterative mul/div unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation of a W-bit value.
module muldiv_negate #(
  parameter int unsigned W = 32
) (
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y_c
);

  assign y_c = en ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with one-cycle sign fix-up.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned XW = XLEN + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic              sign_a_q, sign_b_q;
  logic [XLEN-1:0]   mag_a_q, mag_b_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic [XLEN-1:0]   result_q;
  logic              busy_q, done_q;

  logic              accept_c;
  logic              sign_a_c, sign_b_c;
  logic [XLEN-1:0]   mag_a_c, mag_b_c;
  logic              div_zero_c, ovf_c, special_c;
  logic [XLEN-1:0]   special_res_c;
  logic [XW-1:0]     mul_sum_c, div_shift_c, div_diff_c;
  logic [2*XLEN-1:0] prod_n_c;
  logic [XLEN-1:0]   quo_n_c, rem_n_c, fix_res_c;

  assign sign_a_c = a[XLEN-1] & a_signed(op);
  assign sign_b_c = b[XLEN-1] & b_signed(op);

  muldiv_negate #(.W(XLEN)) u_mag_a (.en(sign_a_c), .x(a), .y_c(mag_a_c));
  muldiv_negate #(.W(XLEN)) u_mag_b (.en(sign_b_c), .x(b), .y_c(mag_b_c));

  muldiv_negate #(.W(2*XLEN)) u_fix_prod (.en(sign_a_q ^ sign_b_q), .x({hi_q, lo_q}), .y_c(prod_n_c));
  muldiv_negate #(.W(XLEN))   u_fix_quo  (.en(sign_a_q ^ sign_b_q), .x(lo_q), .y_c(quo_n_c));
  muldiv_negate #(.W(XLEN))   u_fix_rem  (.en(sign_a_q), .x(hi_q), .y_c(rem_n_c));

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    div_zero_c    = (b == '0);
    ovf_c         = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
    special_c     = is_div(op) && (div_zero_c || ovf_c);
    special_res_c = '0;
    if (div_zero_c) special_res_c = op[1] ? a : '1;
    else if (!op[1]) special_res_c = a;
  end

  // hi/lo hold {acc, multiplier} when multiplying and {remainder, dividend/quotient} when dividing.
  always_comb begin
    mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : XW'(0));
    div_shift_c = {hi_q, lo_q[XLEN-1]};
    div_diff_c  = div_shift_c - {1'b0, mag_b_q};
  end

  always_comb begin
    fix_res_c = '0;
    case (op_q)
      OP_MUL:                       fix_res_c = prod_n_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_c = prod_n_c[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res_c = quo_n_c;
      default:                      fix_res_c = rem_n_c;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          accept_c = 1'b1;
          state_d  = special_c ? S_DONE : S_CALC;
        end
      end
      S_CALC:  if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (kill) begin
      state_d  = S_IDLE;
      accept_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_CALC) || (state_d == S_FIX);
      done_q  <= (state_d == S_DONE);
      if (accept_c) begin
        op_q     <= op;
        sign_a_q <= sign_a_c;
        sign_b_q <= sign_b_c;
        mag_a_q  <= mag_a_c;
        mag_b_q  <= mag_b_c;
        cnt_q    <= CW'(XLEN);
        hi_q     <= '0;
        lo_q     <= is_div(op) ? mag_a_c : mag_b_c;
        if (special_c) result_q <= special_res_c;
      end else if (state_q == S_CALC) begin
        cnt_q <= cnt_q - CW'(1);
        if (is_div(op_q)) begin
          if (!div_diff_c[XLEN]) begin
            hi_q <= div_diff_c[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_q <= div_shift_c[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_q <= mul_sum_c[XLEN:1];
          lo_q <= {mul_sum_c[0], lo_q[XLEN-1:1]};
        end
      end else if ((state_q == S_FIX) && !kill) begin
        result_q <= fix_res_c;
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int num_checks = 0;
  int num_fail   = 0;
  logic [31:0] last;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .kill(kill), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
    logic [63:0] up;
    logic ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin up = {32'b0, x} * {32'b0, y}; return up[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
      3'd3: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Presents a request for one edge; returns one step after that edge (cycle 1).
  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n, output int bc);
    n = n0; bc = 0;
    while (!done && n < 100) begin
      if (busy) bc++;
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic run_dir(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int lat);
    int n, bc;
    launch(o, x, y);
    wait_done(1, n, bc);
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_busy"}, 32'(bc), 32'(lat - 1));
    check(tag, result, exp);
    last = exp;
  endtask

  initial begin
    int n, bc, dcnt;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_dir("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_dir("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_dir("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_dir("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_dir("div_neg",   3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run_dir("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run_dir("divu",      3'd5, 32'd100,        32'd7,         32'd14,        34);
    run_dir("remu",      3'd7, 32'd100,        32'd7,         32'd2,         34);
    run_dir("divu_z",    3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_dir("rem_z",     3'd6, 32'd5,          32'd0,         32'd5,         1);
    run_dir("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_dir("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // A start while busy must be ignored.
    launch(3'd0, 32'd7, 32'hFFFF_FFFD);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; op = 3'd5; a = 32'd5; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(11, n, bc);
    check("ign_lat", 32'(n), 32'd34);
    check("ign_result", result, 32'hFFFF_FFEB);
    last = 32'hFFFF_FFEB;

    // Kill during CALC: no done, result held.
    launch(3'd0, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_done", 32'(done), 32'd0);
    check("kill_result", result, last);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("kill_nodone", 32'(dcnt), 32'd0);
    check("kill_hold", result, last);

    // Kill wins over start in IDLE.
    start = 1'b1; kill = 1'b1; op = 3'd5; a = 32'd9; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("killstart_busy", 32'(busy), 32'd0);
    check("killstart_done", 32'(done), 32'd0);
    check("killstart_result", result, last);

    // Back-to-back start in the DONE cycle.
    launch(3'd5, 32'd1000, 32'd9);
    wait_done(1, n, bc);
    check("b2b1_result", result, 32'd111);
    launch(3'd0, 32'd12, 32'd12);
    wait_done(1, n, bc);
    check("b2b2_lat", 32'(n), 32'd34);
    check("b2b2_result", result, 32'd144);

    // Reset mid-DIV.
    @(posedge clk); #1;
    launch(3'd4, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      launch(ro, ra, rb);
      wait_done(1, n, bc);
      check($sformatf("rnd%0d_op%0d_lat", i, ro), 32'(n), 32'(model_lat(ro, ra, rb)));
      check($sformatf("rnd%0d_op%0d", i, ro), result, model(ro, ra, rb));
      @(posedge clk); #1;
      check($sformatf("rnd%0d_pulse", i), 32'(done), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
